// File: rtl/td4_seq.sv
// td4_seq: fetch/execute sequencer (PC, IR, carry). 2+ cycles per instruction, stalls in FETCH until rom_ack.
// Optional single-step input enabled by defining TD4_SEQ_STEP_EN.
module td4_seq #(
   parameter int PC_W  = 4,
   parameter int IMM_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
`ifdef TD4_SEQ_STEP_EN
   input  logic              step,
`endif
   output logic              rom_req,
   output logic [PC_W-1:0]   rom_addr,
   input  logic              rom_ack,
   input  logic [IMM_W+3:0]  rom_data,
   output logic [3:0]        opcode,
   output logic              carry,
   output logic [IMM_W-1:0]  imm,
   input  logic [3:0]        dec_load_n,
   output logic [3:0]        load_n,
   input  logic              alu_cout,
   output logic [PC_W-1:0]   pc,
   output logic              halted
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [IMM_W+3:0]  ir_q, ir_d;
   logic              carry_q, carry_d;

   logic                   go;
   logic [PC_W+IMM_W-1:0]  imm_ext;
   logic [PC_W+IMM_W-1:0]  pc_ext;
   logic [PC_W-1:0]        imm_pc;
   logic                   self_jump;
   logic                   halt_hit;

`ifdef TD4_SEQ_STEP_EN
   assign go = run | step;
`else
   assign go = run;
`endif

   assign opcode = ir_q[IMM_W+3:IMM_W];
   assign imm    = ir_q[IMM_W-1:0];
   assign carry  = carry_q;
   assign pc     = pc_q;

   // Compare imm and pc at a common width so a wide imm cannot alias a narrow pc.
   assign imm_ext   = {{PC_W{1'b0}}, imm};
   assign pc_ext    = {{IMM_W{1'b0}}, pc_q};
   assign imm_pc    = imm_ext[PC_W-1:0];
   assign self_jump = (imm_ext == pc_ext);
   assign halt_hit  = self_jump &&
                      ((opcode == 4'b1111) || ((opcode == 4'b1110) && !carry_q));

   assign rom_req  = (state_q == ST_FETCH);
   assign rom_addr = pc_q;
   assign load_n   = (state_q == ST_EXEC) ? dec_load_n : 4'b1111;
   assign halted   = (state_q == ST_HALT);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      carry_d = carry_q;
      case (state_q)
         ST_IDLE: begin
            if (go) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (rom_ack) begin
               ir_d    = rom_data;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            carry_d = alu_cout;
            pc_d    = dec_load_n[3] ? pc_q + PC_W'(1) : imm_pc;
            if (halt_hit)  state_d = ST_HALT;
            else if (run)  state_d = ST_FETCH;
            else           state_d = ST_IDLE;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         carry_q <= carry_d;
      end
   end

endmodule

// File: tb/tb_td4_seq.sv
// Bench for td4_seq: acts as ROM and decoder, scoreboards each instruction's EXEC outputs.
module tb_td4_seq;

   logic       clk;
   logic       rst;
   logic       run;
`ifdef TD4_SEQ_STEP_EN
   logic       step;
`endif
   logic       rom_req;
   logic [3:0] rom_addr;
   logic       rom_ack;
   logic [7:0] rom_data;
   logic [3:0] opcode;
   logic       carry;
   logic [3:0] imm;
   logic [3:0] dec_load_n;
   logic [3:0] load_n;
   logic       alu_cout;
   logic [3:0] pc;
   logic       halted;

   td4_seq #(.PC_W(4), .IMM_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
`ifdef TD4_SEQ_STEP_EN
      .step       (step),
`endif
      .rom_req    (rom_req),
      .rom_addr   (rom_addr),
      .rom_ack    (rom_ack),
      .rom_data   (rom_data),
      .opcode     (opcode),
      .carry      (carry),
      .imm        (imm),
      .dec_load_n (dec_load_n),
      .load_n     (load_n),
      .alu_cout   (alu_cout),
      .pc         (pc),
      .halted     (halted)
   );

   typedef struct {
      logic [3:0] ld;
      logic [3:0] op;
      logic [3:0] im;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [3:0] m_pc;
   logic       m_carry;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One instruction: wait for the fetch, ack after dly cycles, check EXEC and the state after it.
   task automatic exec_instr(input logic [7:0] data, input int dly, input logic [3:0] dec,
                             input logic cout, input bit drop_run, output int start);
      exp_t       e;
      int         w;
      logic [3:0] nxt;
      bit         hlt;
      w = 0;
      while (!rom_req && w < 10) begin
         tick();
         w++;
      end
      chk("fetch_req", rom_req, 1);
      start = cyc;
      chk("rom_addr", rom_addr, m_pc);
      if (drop_run) run = 1'b0;
      repeat (dly) tick();
      chk("req_held", rom_req, 1);
      chk("fetch_ldn", load_n, 4'hF);
      rom_ack    = 1'b1;
      rom_data   = data;
      dec_load_n = dec;
      alu_cout   = cout;
      e.ld = dec;
      e.op = data[7:4];
      e.im = data[3:0];
      sb.push_back(e);
      nxt = dec[3] ? m_pc + 4'd1 : data[3:0];
      hlt = (data[3:0] == m_pc) && ((data[7:4] == 4'hF) || ((data[7:4] == 4'hE) && !m_carry));
      tick();
      rom_ack  = 1'b0;
      rom_data = 8'h00;
      chk("req_drop", rom_req, 0);
      e = sb.pop_front();
      chk("exec_ldn", load_n, e.ld);
      chk("opcode", opcode, e.op);
      chk("imm", imm, e.im);
      tick();
      dec_load_n = 4'h0;
      m_pc    = nxt;
      m_carry = cout;
      chk("pc", pc, m_pc);
      chk("carry", carry, m_carry);
      chk("halted", halted, hlt);
      chk("post_ldn", load_n, 4'hF);
   endtask

   task automatic expect_quiet(input string tag, input int n);
      int cnt;
      cnt = 0;
      repeat (n) begin
         tick();
         if (rom_req) cnt++;
      end
      chk(tag, cnt, 0);
   endtask

   initial begin
      int s0, s1, s2, t;
      rst = 1'b1; run = 1'b0; rom_ack = 1'b0; rom_data = 8'h00;
      dec_load_n = 4'h0; alu_cout = 1'b0;
`ifdef TD4_SEQ_STEP_EN
      step = 1'b0;
`endif
      repeat (2) tick();
      chk("rst_req", rom_req, 0);
      chk("rst_pc", pc, 0);
      chk("rst_ldn", load_n, 4'hF);
      chk("rst_halted", halted, 0);
      chk("rst_op", opcode, 0);
      chk("rst_carry", carry, 0);
      rst = 1'b0; run = 1'b1; m_pc = 4'd0; m_carry = 1'b0;

      // Straight-line code with ack delays 0, 3, 0
      exec_instr(8'h35, 0, 4'hE, 1'b0, 0, s0);
      exec_instr(8'h72, 3, 4'hD, 1'b0, 0, s1);
      exec_instr(8'h01, 0, 4'hE, 1'b0, 0, s2);
      chk("space01", s1 - s0, 2);
      chk("space12", s2 - s1, 5);
      exec_instr(8'h33, 1, 4'hE, 1'b0, 0, t);
      exec_instr(8'h01, 0, 4'hE, 1'b1, 0, t);   // pc4 ADD sets carry
      exec_instr(8'hE9, 2, 4'hF, 1'b0, 0, t);   // pc5 JNC not taken
      exec_instr(8'h01, 0, 4'hE, 1'b1, 0, t);   // pc6, carry=1 again

      // Reset mid-fetch with a coincident ack
      chk("mid_req", rom_req, 1);
      rst = 1'b1; rom_ack = 1'b1; rom_data = 8'hF7;
      tick();
      chk("mrst_req", rom_req, 0);
      chk("mrst_pc", pc, 0);
      chk("mrst_op", opcode, 0);
      chk("mrst_imm", imm, 0);
      chk("mrst_carry", carry, 0);
      chk("mrst_ldn", load_n, 4'hF);
      chk("mrst_halted", halted, 0);
      rst = 1'b0; rom_ack = 1'b0; rom_data = 8'h00;
      m_pc = 4'd0; m_carry = 1'b0;

      // PC wrap 15 -> 0, then jump to 7 and self-jump halt
      exec_instr(8'hFF, 0, 4'h7, 1'b0, 0, t);
      exec_instr(8'h32, 1, 4'hE, 1'b1, 0, t);
      exec_instr(8'hF7, 0, 4'h7, 1'b0, 0, t);
      exec_instr(8'hF7, 2, 4'h7, 1'b0, 0, t);
      expect_quiet("halt_noreq", 20);
      chk("halt_hold", halted, 1);
      chk("halt_ldn", load_n, 4'hF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_pc = 4'd0; m_carry = 1'b0;
      chk("unhalt", halted, 0);

      // run dropped during FETCH: instruction completes, then idles
      exec_instr(8'h33, 1, 4'hE, 1'b0, 1, t);
      expect_quiet("idle_noreq", 10);

`ifdef TD4_SEQ_STEP_EN
      step = 1'b1;
      tick();
      step = 1'b0;
      exec_instr(8'h71, 1, 4'hD, 1'b0, 0, t);
      expect_quiet("step_noreq", 10);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
